// File: rtl/ld_cell_a2d_seq.sv
// ld_cell_a2d_seq: SPI A2D round-robin sequencer (lft/rght/steer/batt); LD_AVG_EN enables load-cell averaging
module ld_cell_a2d_seq #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        ld_vld
);
  typedef enum logic [2:0] {IDLE, TXN1, GAP, TXN2, WR} state_t;
  state_t      r_state, w_state_nxt;
  logic        w_start, w_wr, w_bad, w_done;
  logic        r_ss_n, r_ld_vld;
  logic [4:0]  r_div, r_cnt;
  logic [15:0] r_tx;
  logic [11:0] r_rx, r_steer, r_batt;
  logic [1:0]  r_ptr;
  logic [2:0]  w_ch;

  assign w_ch = r_ptr == 2'd0 ? CH_LFT : r_ptr == 2'd1 ? CH_RGHT : r_ptr == 2'd2 ? CH_STEER : CH_BATT;
  assign w_done = !r_ss_n && r_div == 5'b11111 && r_cnt == 5'd16;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  // Two back-to-back SPI frames per conversion: the first addresses the channel, the second returns it
  always_comb begin
    w_state_nxt = r_state;
    w_start = 1'b0;
    w_wr = 1'b0;
    w_bad = 1'b0;
    case (r_state)
      IDLE: begin w_state_nxt = nxt ? TXN1 : IDLE; w_start = nxt; end
      TXN1: w_state_nxt = w_done ? GAP : TXN1;
      GAP:  begin w_state_nxt = TXN2; w_start = 1'b1; end
      TXN2: w_state_nxt = w_done ? WR : TXN2;
      WR:   begin w_state_nxt = IDLE; w_wr = 1'b1; end
      default: begin w_state_nxt = IDLE; w_bad = 1'b1; end
    endcase
  end

  // SPI master: SCLK = div[4]; sample MISO before rise, shift MOSI before fall (not before the first rise)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ss_n <= 1'b1;
      r_div <= 5'b10111;
      r_cnt <= '0;
      r_tx <= '0;
      r_rx <= '0;
    end else if (w_start) begin
      r_ss_n <= 1'b0;
      r_div <= 5'b10111;
      r_cnt <= '0;
      r_tx <= {2'b00, w_ch, 11'h000};
    end else if (w_bad) r_ss_n <= 1'b1;
    else if (!r_ss_n) begin
      r_div <= r_div + 5'd1;
      if (r_div == 5'b01111 && r_cnt != 5'd16) begin
        r_rx <= {r_rx[10:0], MISO};
        r_cnt <= r_cnt + 5'd1;
      end
      if (r_div == 5'b11111) begin
        if (r_cnt == 5'd16) r_ss_n <= 1'b1;
        else if (r_cnt != 5'd0) r_tx <= {r_tx[14:0], 1'b0};
      end
    end

  assign SS_n = r_ss_n;
  assign SCLK = r_ss_n | r_div[4];
  assign MOSI = !r_ss_n && r_tx[15];

  // Channel pointer, raw steer/batt results and the coherent-pair strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr <= '0;
      r_ld_vld <= 1'b0;
      r_steer <= '0;
      r_batt <= '0;
    end else begin
      r_ld_vld <= w_wr && r_ptr == 2'd1;
      if (w_wr) r_ptr <= r_ptr + 2'd1;
      if (w_wr && r_ptr == 2'd2) r_steer <= r_rx;
      if (w_wr && r_ptr == 2'd3) r_batt <= r_rx;
    end

  assign steer_pot = r_steer;
  assign batt = r_batt;
  assign ld_vld = r_ld_vld;

`ifdef LD_AVG_EN
  logic [11:0] r_lh [4];
  logic [11:0] r_rh [4];
  logic [13:0] r_lsum, r_rsum;

  // Running 4-sample sums; history starts at zero so the first outputs ramp up
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_lh[i] <= '0;
        r_rh[i] <= '0;
      end
      r_lsum <= '0;
      r_rsum <= '0;
    end else begin
      if (w_wr && r_ptr == 2'd0) begin
        r_lh[0] <= r_rx;
        for (int i = 1; i < 4; i++) r_lh[i] <= r_lh[i-1];
        r_lsum <= r_lsum + {2'b00, r_rx} - {2'b00, r_lh[3]};
      end
      if (w_wr && r_ptr == 2'd1) begin
        r_rh[0] <= r_rx;
        for (int i = 1; i < 4; i++) r_rh[i] <= r_rh[i-1];
        r_rsum <= r_rsum + {2'b00, r_rx} - {2'b00, r_rh[3]};
      end
    end

  assign lft_ld = r_lsum[13:2];
  assign rght_ld = r_rsum[13:2];
`else
  logic [11:0] r_lft, r_rght;

  // Raw load-cell results
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lft <= '0;
      r_rght <= '0;
    end else begin
      if (w_wr && r_ptr == 2'd0) r_lft <= r_rx;
      if (w_wr && r_ptr == 2'd1) r_rght <= r_rx;
    end

  assign lft_ld = r_lft;
  assign rght_ld = r_rght;
`endif
endmodule

// File: tb/tb_ld_cell_a2d_seq.sv
// tb_ld_cell_a2d_seq: ADC128S-style slave model plus reference model of the round-robin sequencer
module tb_ld_cell_a2d_seq;
  logic clk = 1'b0, rst_n = 1'b1, nxt = 1'b0, MISO;
  logic SS_n, SCLK, MOSI, ld_vld;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  always #5 clk = ~clk;

  ld_cell_a2d_seq dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt), .ld_vld(ld_vld)
  );

  // ADC slave: latches channel from a full frame, returns it during the next frame MSB first
  logic [11:0] adc [8];
  int rises = 0, base = 0, per_err = 0, err_base = 0, nfr = 0, kk;
  time last_t = 0;
  logic [15:0] mo = '0, dw;
  logic [2:0] addr = '0;
  int fr_n [256];
  int fr_err [256];
  logic [15:0] fr_cmd [256];

  assign kk = rises - base;
  assign dw = {4'h0, adc[addr]};
  assign MISO = (kk >= 0 && kk < 16) ? dw[15-kk] : 1'b0;

  always @(negedge SS_n) begin
    base = rises;
    err_base = per_err;
  end

  always @(posedge SCLK) begin
    if (!SS_n && rises > base && $time - last_t != 320) per_err++;
    last_t = $time;
    rises++;
    mo = {mo[14:0], MOSI};
  end

  always @(posedge SS_n) begin
    if (nfr < 256) begin
      fr_n[nfr] = rises - base;
      fr_cmd[nfr] = mo;
      fr_err[nfr] = per_err - err_base;
    end
    if (rises - base == 16) addr = mo[13:11];
    nfr++;
  end

  int idle_bad = 0, nvld = 0;
  logic [11:0] vld_rght = '0;
  always @(negedge clk) begin
    if (SS_n && !SCLK) idle_bad++;
    if (ld_vld) begin
      nvld++;
      vld_rght = rght_ld;
    end
  end

  // Reference model: conversion index picks channel; load cells optionally averaged over last 4 samples
  logic [2:0] chs [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  logic [11:0] exp_o [4];
  logic [11:0] hl [$];
  logic [11:0] hr [$];
  int idx;
  int n_assert = 0, n_fail = 0;

  task automatic model_reset();
    idx = 0;
    for (int i = 0; i < 4; i++) exp_o[i] = '0;
    hl.delete();
    hr.delete();
  endtask

  task automatic model_conv(input logic [11:0] v);
    int p, s;
    p = idx % 4;
    exp_o[p] = v;
`ifdef LD_AVG_EN
    if (p == 0) begin
      hl.push_front(v);
      if (hl.size() > 4) void'(hl.pop_back());
      s = 0;
      foreach (hl[i]) s += hl[i];
      exp_o[0] = 12'(s / 4);
    end
    if (p == 1) begin
      hr.push_front(v);
      if (hr.size() > 4) void'(hr.pop_back());
      s = 0;
      foreach (hr[i]) s += hr[i];
      exp_o[1] = 12'(s / 4);
    end
`endif
    idx++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("lft_ld", lft_ld, exp_o[0]);
    chk("rght_ld", rght_ld, exp_o[1]);
    chk("steer_pot", steer_pot, exp_o[2]);
    chk("batt", batt, exp_o[3]);
  endtask

  task automatic conv(input bit busy_nxt);
    int p, n0, v0, low;
    bit ok;
    logic [2:0] ch;
    logic [11:0] v;
    p = idx % 4;
    ch = chs[p];
    v = adc[ch];
    n0 = nfr;
    v0 = nvld;
    ok = 1'b0;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    chk("ss_start", SS_n, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      nxt = 1'b0;
      if (nfr >= n0 + 2) begin
        ok = 1'b1;
        break;
      end
      if (busy_nxt && i % 100 == 50) nxt = 1'b1;
    end
    chk("conv_done", ok, 1'b1);
    repeat (3) @(negedge clk);
    model_conv(v);
    for (int f = n0; f < n0 + 2; f++) begin
      chk("frm_rises", fr_n[f], 16);
      chk("frm_cmd", fr_cmd[f], {2'b00, ch, 11'h000});
      chk("frm_period", fr_err[f], 0);
    end
    chk_outs();
    chk("ld_vld_cnt", nvld - v0, p == 1);
    if (p == 1) chk("ld_vld_rght", vld_rght, exp_o[1]);
    if (busy_nxt) begin
      low = 0;
      repeat (150) begin
        @(negedge clk);
        if (!SS_n) low++;
      end
      chk("no_queue", low, 0);
    end
  endtask

  task automatic rand_adc();
    for (int i = 0; i < 8; i++) adc[i] = 12'($urandom);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ss_n", SS_n, 1'b1);
    chk("rst_sclk", SCLK, 1'b1);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_ld_vld", ld_vld, 1'b0);
    chk("rst_lft", lft_ld, 12'h000);
    chk("rst_rght", rght_ld, 12'h000);
    chk("rst_steer", steer_pot, 12'h000);
    chk("rst_batt", batt, 12'h000);
  endtask

  initial begin
    int n0, v0;
    bit ok;
    for (int i = 0; i < 8; i++) adc[i] = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    // Directed values, one full round
    adc[0] = 12'h300;
    adc[4] = 12'h280;
    adc[5] = 12'h800;
    adc[6] = 12'hC00;
    for (int i = 0; i < 4; i++) conv(1'b0);
    // Random values, wraps back to lft, alternate busy-time nxt pulses
    for (int i = 0; i < 5; i++) begin
      rand_adc();
      conv(i % 2 == 1);
    end
    // Abort mid-TXN2 of the rght conversion
    chk("abort_slot_rght", idx % 4, 1);
    rand_adc();
    n0 = nfr;
    v0 = nvld;
    ok = 1'b0;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (nfr >= n0 + 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("txn1_done", ok, 1'b1);
    repeat (200) @(negedge clk);
    chk("mid_txn2", SS_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_vld", nvld - v0, 0);
    model_reset();
    rand_adc();
    conv(1'b0);
    // Constant lft input from a fresh reset: ramp (averaged) or immediate (raw)
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      rand_adc();
      adc[0] = 12'h400;
      conv(1'b0);
    end
    chk("lft_steady", lft_ld, 12'h400);
    chk("sclk_idle_high", idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
